// File: rtl/showahead_sync_fifo_wm.sv
// Single-clock show-ahead FIFO using all DEPTH entries, with watermarks, flush and occupancy count.
// Latency: write at edge k is visible on oRD_DATA (and !oRD_EMPTY) after edge k; the head is combinational.
// Backpressure: writes are dropped when full unless a same-cycle read frees the slot; reads are dropped when empty.
//
// Ports:
//   iCLOCK, inRESET (async, active low), iRESET_SYNC (sync flush, active high)
//   iWR_EN/iWR_DATA in, oWR_FULL/oWR_ALMOST_FULL out
//   iRD_EN in, oRD_DATA/oRD_EMPTY/oRD_ALMOST_EMPTY out, oCOUNT out (0..DEPTH)
//   With SHOWAHEAD_SYNC_FIFO_ERR_EN defined: iERR_CLEAR in, oERR_OVERFLOW/oERR_UNDERFLOW out (sticky)
module showahead_sync_fifo_wm #(
    parameter int N        = 16,
    parameter int DEPTH    = 16,
    parameter int D_N      = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic         iCLOCK,
    input  logic         inRESET,
    input  logic         iRESET_SYNC,
    input  logic         iWR_EN,
    input  logic [N-1:0] iWR_DATA,
    output logic         oWR_FULL,
    output logic         oWR_ALMOST_FULL,
    input  logic         iRD_EN,
    output logic [N-1:0] oRD_DATA,
    output logic         oRD_EMPTY,
    output logic         oRD_ALMOST_EMPTY,
    output logic [D_N:0] oCOUNT
`ifdef SHOWAHEAD_SYNC_FIFO_ERR_EN
    ,
    input  logic         iERR_CLEAR,
    output logic         oERR_OVERFLOW,
    output logic         oERR_UNDERFLOW
`endif
);

    localparam logic [D_N:0] DEPTH_C = DEPTH[D_N:0];
    localparam logic [D_N:0] AF_C    = AF_LEVEL[D_N:0];
    localparam logic [D_N:0] AE_C    = AE_LEVEL[D_N:0];
    localparam logic [D_N:0] ZERO_C  = '0;
    localparam logic [D_N:0] ONE_C   = {{D_N{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so the modular difference spans 0..DEPTH.
    logic [D_N:0] wr_ptr;
    logic [D_N:0] rd_ptr;
    logic [D_N:0] count;
    logic [N-1:0] mem [DEPTH];

    logic full;
    logic empty;
    logic rd_acc;
    logic wr_acc;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH_C);
    assign empty = (count == ZERO_C);

    assign rd_acc = iRD_EN && !empty;
    // At full a simultaneous pop frees the slot being written into.
    assign wr_acc = iWR_EN && (!full || iRD_EN);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (iRESET_SYNC) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
            if (rd_acc) rd_ptr <= rd_ptr + ONE_C;
        end
    end

    // Storage is not reset; a flush only moves the pointers.
    always_ff @(posedge iCLOCK) begin
        if (wr_acc && !iRESET_SYNC) begin
            mem[wr_ptr[D_N-1:0]] <= iWR_DATA;
        end
    end

    assign oRD_DATA         = mem[rd_ptr[D_N-1:0]];
    assign oRD_EMPTY        = empty;
    assign oWR_FULL         = full;
    assign oWR_ALMOST_FULL  = (count >= AF_C);
    assign oRD_ALMOST_EMPTY = (count <= AE_C);
    assign oCOUNT           = count;

`ifdef SHOWAHEAD_SYNC_FIFO_ERR_EN
    logic ovf_set;
    logic unf_set;
    logic err_ovf;
    logic err_unf;

    assign ovf_set = iWR_EN && full && !iRD_EN;
    // Any read request while empty counts, including the empty read+write case.
    assign unf_set = iRD_EN && empty;

    // Sticky flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (ovf_set)         err_ovf <= 1'b1;
            else if (iERR_CLEAR) err_ovf <= 1'b0;
            if (unf_set)         err_unf <= 1'b1;
            else if (iERR_CLEAR) err_unf <= 1'b0;
        end
    end

    assign oERR_OVERFLOW  = err_ovf;
    assign oERR_UNDERFLOW = err_unf;
`endif

endmodule
